// File: rtl/pieo_op_sched.sv
// Single-issue command scheduler in front of the PIEO sorted-list core.
// Round-robin arbitration between enqueue and dequeue, with occupancy-based rejection.
module pieo_op_sched #(
  parameter int unsigned LIST_SIZE = 9,
  parameter int unsigned ELEM_W    = 18,
  parameter int unsigned TIME_LOG  = 6,
  parameter int unsigned CNT_W     = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enq_valid,
  output logic                enq_ready,
  input  logic [ELEM_W-1:0]   enq_elem,
  input  logic                deq_valid,
  output logic                deq_ready,
  input  logic [TIME_LOG-1:0] deq_curr_time,
  output logic                resp_valid,
  output logic                resp_op,
  output logic [1:0]          resp_status,
  output logic [ELEM_W-1:0]   resp_elem,
  output logic                pieo_start,
  output logic                pieo_op,
  output logic [ELEM_W-1:0]   pieo_elem,
  output logic [TIME_LOG-1:0] pieo_curr_time,
  input  logic                pieo_ready,
  input  logic                pieo_done,
  input  logic                pieo_deq_valid,
  input  logic [ELEM_W-1:0]   pieo_deq_elem,
  output logic [CNT_W-1:0]    occupancy,
  output logic                full,
  output logic                empty
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  localparam logic       OpEnq       = 1'b0;
  localparam logic       OpDeq       = 1'b1;
  localparam logic [1:0] StatOk      = 2'b00;
  localparam logic [1:0] StatFull    = 2'b01;
  localparam logic [1:0] StatEmpty   = 2'b10;
  localparam logic [1:0] StatNotElig = 2'b11;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      occ_q, occ_d;
  logic                  last_grant_q, last_grant_d;
  logic                  cmd_op_q, cmd_op_d;
  logic [ELEM_W-1:0]     cmd_elem_q, cmd_elem_d;
  logic [TIME_LOG-1:0]   cmd_time_q, cmd_time_d;
  logic                  resp_op_q, resp_op_d;
  logic [1:0]            resp_status_q, resp_status_d;
  logic [ELEM_W-1:0]     resp_elem_q, resp_elem_d;
  logic                  grant_enq, grant_deq;
  logic                  cmd_active;

  assign full       = (occ_q == CNT_W'(LIST_SIZE));
  assign empty      = (occ_q == '0);
  assign occupancy  = occ_q;
  assign cmd_active = (state_q == StIssue) || (state_q == StWait);

  // Core-facing command fields read zero outside the issue/wait window.
  assign pieo_op        = cmd_active & cmd_op_q;
  assign pieo_elem      = cmd_active ? cmd_elem_q : '0;
  assign pieo_curr_time = cmd_active ? cmd_time_q : '0;

  assign resp_valid  = (state_q == StResp);
  assign resp_op     = resp_valid & resp_op_q;
  assign resp_status = resp_valid ? resp_status_q : '0;
  assign resp_elem   = resp_valid ? resp_elem_q : '0;

  always_comb begin
    state_d       = state_q;
    occ_d         = occ_q;
    last_grant_d  = last_grant_q;
    cmd_op_d      = cmd_op_q;
    cmd_elem_d    = cmd_elem_q;
    cmd_time_d    = cmd_time_q;
    resp_op_d     = resp_op_q;
    resp_status_d = resp_status_q;
    resp_elem_d   = resp_elem_q;
    grant_enq     = 1'b0;
    grant_deq     = 1'b0;
    enq_ready     = 1'b0;
    deq_ready     = 1'b0;
    pieo_start    = 1'b0;

    unique case (state_q)
      StIdle: begin
        // On a tie, grant whichever side did not win last time.
        grant_enq = enq_valid && (!deq_valid || (last_grant_q == OpDeq));
        grant_deq = deq_valid && !grant_enq;
        enq_ready = grant_enq;
        deq_ready = grant_deq;
        if (grant_enq) begin
          last_grant_d = OpEnq;
          cmd_op_d     = OpEnq;
          cmd_elem_d   = enq_elem;
          if (full) begin
            resp_op_d     = OpEnq;
            resp_status_d = StatFull;
            resp_elem_d   = '0;
            state_d       = StResp;
          end else begin
            state_d = StIssue;
          end
        end else if (grant_deq) begin
          last_grant_d = OpDeq;
          cmd_op_d     = OpDeq;
          cmd_time_d   = deq_curr_time;
          if (empty) begin
            resp_op_d     = OpDeq;
            resp_status_d = StatEmpty;
            resp_elem_d   = '0;
            state_d       = StResp;
          end else begin
            state_d = StIssue;
          end
        end
      end

      StIssue: begin
        pieo_start = pieo_ready;
        if (pieo_ready) begin
          state_d = StWait;
        end
      end

      StWait: begin
        if (pieo_done) begin
          state_d     = StResp;
          resp_op_d   = cmd_op_q;
          resp_elem_d = '0;
          if (cmd_op_q == OpEnq) begin
            resp_status_d = StatOk;
            occ_d         = occ_q + CNT_W'(1);
          end else if (pieo_deq_valid) begin
            resp_status_d = StatOk;
            resp_elem_d   = pieo_deq_elem;
            occ_d         = occ_q - CNT_W'(1);
          end else begin
            resp_status_d = StatNotElig;
          end
        end
      end

      StResp: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      occ_q         <= '0;
      last_grant_q  <= OpDeq;
      cmd_op_q      <= OpEnq;
      cmd_elem_q    <= '0;
      cmd_time_q    <= '0;
      resp_op_q     <= OpEnq;
      resp_status_q <= StatOk;
      resp_elem_q   <= '0;
    end else begin
      state_q       <= state_d;
      occ_q         <= occ_d;
      last_grant_q  <= last_grant_d;
      cmd_op_q      <= cmd_op_d;
      cmd_elem_q    <= cmd_elem_d;
      cmd_time_q    <= cmd_time_d;
      resp_op_q     <= resp_op_d;
      resp_status_q <= resp_status_d;
      resp_elem_q   <= resp_elem_d;
    end
  end

endmodule

// File: tb/tb_pieo_op_sched.sv
// Self-checking bench for pieo_op_sched: directed transaction table, hand-written
// reset sequence and randomized traffic against a transaction-level model.
module tb_pieo_op_sched;

  localparam int LS = 9;

  localparam logic [1:0] SOk = 2'b00, SFull = 2'b01, SEmpty = 2'b10, SNe = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enq_valid = 1'b0, enq_ready;
  logic [17:0] enq_elem = '0;
  logic        deq_valid = 1'b0, deq_ready;
  logic [5:0]  deq_curr_time = '0;
  logic        resp_valid, resp_op;
  logic [1:0]  resp_status;
  logic [17:0] resp_elem;
  logic        pieo_start, pieo_op;
  logic [17:0] pieo_elem;
  logic [5:0]  pieo_curr_time;
  logic        pieo_ready = 1'b0, pieo_done = 1'b0, pieo_deq_valid = 1'b0;
  logic [17:0] pieo_deq_elem = '0;
  logic [3:0]  occupancy;
  logic        full, empty;

  pieo_op_sched #(.LIST_SIZE(9), .ELEM_W(18), .TIME_LOG(6), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_elem(enq_elem),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_curr_time(deq_curr_time),
    .resp_valid(resp_valid), .resp_op(resp_op), .resp_status(resp_status),
    .resp_elem(resp_elem),
    .pieo_start(pieo_start), .pieo_op(pieo_op), .pieo_elem(pieo_elem),
    .pieo_curr_time(pieo_curr_time), .pieo_ready(pieo_ready), .pieo_done(pieo_done),
    .pieo_deq_valid(pieo_deq_valid), .pieo_deq_elem(pieo_deq_elem),
    .occupancy(occupancy), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          ev;
    bit          dq;
    logic [17:0] elem;
    logic [5:0]  tm;
    int          rdly;
    int          ddly;
    bit          spur;
    bit          cdv;
    logic [17:0] celem;
    bit          xop;
    logic [1:0]  xst;
    logic [17:0] xelem;
    int          xocc;
  } txn_t;

  int n_vec = 0;
  int n_bad = 0;
  int exp_occ = 0;
  bit model_last = 1'b1;  // 1 = dequeue won last

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic junk();
    enq_valid     = 1'($urandom_range(0, 1));
    deq_valid     = 1'($urandom_range(0, 1));
    enq_elem      = 18'($urandom);
    deq_curr_time = 6'($urandom);
  endtask

  task automatic quiet();
    enq_valid = 1'b0; deq_valid = 1'b0; pieo_ready = 1'b0; pieo_done = 1'b0;
    pieo_deq_valid = 1'b0;
  endtask

  task automatic chk_cmd(input txn_t t);
    chk("pieo_op", pieo_op, t.xop);
    if (!t.xop) chk("pieo_elem", pieo_elem, t.elem);
    else        chk("pieo_curr_time", pieo_curr_time, t.tm);
    chk("ready_busy", {enq_ready, deq_ready}, 0);
  endtask

  task automatic run_txn(input txn_t t);
    bit rej;
    rej = (t.xst == SFull) || (t.xst == SEmpty);
    @(negedge clk);
    enq_valid = t.ev; deq_valid = t.dq; enq_elem = t.elem; deq_curr_time = t.tm;
    pieo_ready = 1'($urandom_range(0, 1)); pieo_done = 1'($urandom_range(0, 1));
    #1;
    chk("resp_valid_idle", resp_valid, 0);
    chk("pieo_start_idle", pieo_start, 0);
    chk("occupancy_pre", occupancy, exp_occ);
    chk("full_pre", full, exp_occ == LS);
    chk("empty_pre", empty, exp_occ == 0);
    chk("enq_ready", enq_ready, !t.xop);
    chk("deq_ready", deq_ready, t.xop);
    @(negedge clk);
    junk();
    pieo_done  = t.spur;
    pieo_ready = rej ? 1'($urandom_range(0, 1)) : (t.rdly == 0);
    if (rej) begin
      #1;
      chk("rej_resp_valid", resp_valid, 1);
      chk("rej_resp_op", resp_op, t.xop);
      chk("rej_resp_status", resp_status, t.xst);
      chk("rej_resp_elem", resp_elem, 0);
      chk("rej_no_start", pieo_start, 0);
      chk("rej_ready", {enq_ready, deq_ready}, 0);
      chk("rej_occupancy", occupancy, t.xocc);
    end else begin
      for (int i = 0; i < t.rdly; i++) begin
        #1;
        chk("start_while_not_ready", pieo_start, 0);
        chk_cmd(t);
        @(negedge clk);
        junk();
        pieo_ready = (i == t.rdly - 1);
        pieo_done  = t.spur;
      end
      #1;
      chk("pieo_start", pieo_start, 1);
      chk("resp_in_issue", resp_valid, 0);
      chk_cmd(t);
      for (int i = 0; i < t.ddly; i++) begin
        @(negedge clk);
        junk();
        pieo_ready = 1'($urandom_range(0, 1)); pieo_done = 1'b0;
        #1;
        chk("start_in_wait", pieo_start, 0);
        chk("resp_in_wait", resp_valid, 0);
        chk_cmd(t);
      end
      @(negedge clk);
      junk();
      pieo_ready = 1'($urandom_range(0, 1));
      pieo_done = 1'b1; pieo_deq_valid = t.cdv; pieo_deq_elem = t.celem;
      #1;
      chk("resp_at_done", resp_valid, 0);
      chk("start_at_done", pieo_start, 0);
      @(negedge clk);
      junk();
      pieo_done = 1'($urandom_range(0, 1)); pieo_deq_valid = 1'($urandom_range(0, 1));
      pieo_deq_elem = 18'($urandom);
      #1;
      chk("resp_valid", resp_valid, 1);
      chk("resp_op", resp_op, t.xop);
      chk("resp_status", resp_status, t.xst);
      chk("resp_elem", resp_elem, t.xelem);
      chk("occupancy_post", occupancy, t.xocc);
      chk("start_in_resp", pieo_start, 0);
    end
    exp_occ    = t.xocc;
    model_last = t.xop;
  endtask

  function automatic txn_t mk(bit ev, bit dq, logic [17:0] elem, logic [5:0] tm, int rdly,
                              int ddly, bit spur, bit cdv, logic [17:0] celem, bit xop,
                              logic [1:0] xst, logic [17:0] xelem, int xocc);
    txn_t t;
    t.ev = ev; t.dq = dq; t.elem = elem; t.tm = tm; t.rdly = rdly; t.ddly = ddly;
    t.spur = spur; t.cdv = cdv; t.celem = celem; t.xop = xop; t.xst = xst;
    t.xelem = xelem; t.xocc = xocc;
    return t;
  endfunction

  // Reference: round-robin on ties, reject on full/empty, count elements held.
  task automatic model_txn(input bit ev, input bit dq, input logic [17:0] elem,
                           input logic [5:0] tm, input int rdly, input int ddly,
                           input bit spur, input bit cdv, input logic [17:0] celem);
    bit g;
    txn_t t;
    g = (ev && dq) ? !model_last : dq;
    t = mk(ev, dq, elem, tm, rdly, ddly, spur, cdv, celem, g, SOk, '0, exp_occ);
    if (!g) begin
      if (exp_occ == LS) t.xst = SFull;
      else t.xocc = exp_occ + 1;
    end else if (exp_occ == 0) begin
      t.xst = SEmpty;
    end else if (cdv) begin
      t.xelem = celem;
      t.xocc  = exp_occ - 1;
    end else begin
      t.xst = SNe;
    end
    run_txn(t);
  endtask

  txn_t tbl[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Ties after reset: enq, deq, enq; first enqueue done 3 cycles after start.
    tbl.push_back(mk(1, 1, 18'h1A5B3, 6'h00, 0, 2, 0, 0, 18'h0, 0, SOk, 18'h0, 1));
    tbl.push_back(mk(1, 1, 18'h00777, 6'h21, 0, 0, 0, 1, 18'h3C0F0, 1, SOk, 18'h3C0F0, 0));
    tbl.push_back(mk(1, 1, 18'h01234, 6'h05, 1, 1, 0, 0, 18'h0, 0, SOk, 18'h0, 1));
    for (int i = 2; i <= LS; i++)
      tbl.push_back(mk(1, 0, 18'(i * 18'h1111), 6'h0, i % 2, i % 3, 0, 0, 18'h0, 0, SOk,
                       18'h0, i));
    tbl.push_back(mk(1, 0, 18'h2FFFF, 6'h0, 0, 0, 0, 0, 18'h0, 0, SFull, 18'h0, LS));
    for (int i = LS - 1; i >= 0; i--)
      tbl.push_back(mk(0, 1, 18'h0, 6'(i + 1), 0, i % 2, 0, 1, 18'(18'h10000 + i), 1, SOk,
                       18'(18'h10000 + i), i));
    tbl.push_back(mk(0, 1, 18'h0, 6'h3F, 0, 0, 0, 1, 18'h12345, 1, SEmpty, 18'h0, 0));
    tbl.push_back(mk(1, 0, 18'h0AAAA, 6'h0, 0, 0, 0, 0, 18'h0, 0, SOk, 18'h0, 1));
    tbl.push_back(mk(1, 0, 18'h05555, 6'h0, 0, 1, 0, 0, 18'h0, 0, SOk, 18'h0, 2));
    tbl.push_back(mk(0, 1, 18'h0, 6'h01, 0, 2, 0, 0, 18'h15555, 1, SNe, 18'h0, 2));
    tbl.push_back(mk(0, 1, 18'h0, 6'h02, 0, 1, 0, 1, 18'h00F21, 1, SOk, 18'h00F21, 1));
    // Core not ready for 5 cycles, spurious done while in issue.
    tbl.push_back(mk(1, 0, 18'h3ABCD, 6'h0, 5, 1, 1, 0, 18'h0, 0, SOk, 18'h0, 2));
    tbl.push_back(mk(0, 1, 18'h0, 6'h3F, 2, 3, 1, 1, 18'h2468A, 1, SOk, 18'h2468A, 1));

    #1 rst = 1'b1;
    #2;
    chk("rst_occupancy", occupancy, 0);
    chk("rst_empty", empty, 1);
    chk("rst_outputs", {enq_ready, deq_ready, resp_valid, resp_op, resp_status, resp_elem,
                        pieo_start, pieo_op, pieo_elem, pieo_curr_time, full}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) run_txn(tbl[i]);

    // Asynchronous reset while a core enqueue is outstanding at occupancy 4.
    while (exp_occ < 4) model_txn(1, 0, 18'($urandom), 6'h0, 0, 0, 0, 0, 18'h0);
    while (exp_occ > 4) model_txn(0, 1, 18'h0, 6'h1, 0, 0, 0, 1, 18'($urandom));
    @(negedge clk);
    quiet();
    enq_valid = 1'b1; enq_elem = 18'h0BEEF;
    #1 chk("rw_enq_ready", enq_ready, 1);
    @(negedge clk);
    quiet(); pieo_ready = 1'b1;
    #1 chk("rw_start", pieo_start, 1);
    @(negedge clk);
    pieo_ready = 1'b0;
    #1 chk("rw_occ_wait", occupancy, 4);
    #2 rst = 1'b1;
    #1;
    chk("rw_occupancy", occupancy, 0);
    chk("rw_empty", empty, 1);
    chk("rw_resp_valid", resp_valid, 0);
    chk("rw_pieo_elem", pieo_elem, 0);
    @(negedge clk);
    pieo_done = 1'b1; pieo_ready = 1'b1;
    #1 chk("rw_idle_start", pieo_start, 0);
    @(negedge clk);
    #1 chk("rw_no_resp", resp_valid, 0);
    rst = 1'b0;
    quiet();
    exp_occ    = 0;
    model_last = 1'b1;
    model_txn(1, 1, 18'h1C0DE, 6'h2A, 0, 1, 0, 0, 18'h0);
    model_txn(1, 1, 18'h00001, 6'h15, 1, 0, 0, 1, 18'h31415);

    // Randomized traffic, biased in phases so both full and empty are reached.
    for (int k = 0; k < 300; k++) begin
      int  r;
      bit  ev, dq;
      r = $urandom_range(0, 99);
      if (r < 25) begin
        ev = 1; dq = 1;
      end else begin
        ev = ($urandom_range(0, 99) < (((k / 40) % 2) ? 25 : 75));
        dq = !ev;
      end
      model_txn(ev, dq, 18'($urandom), 6'($urandom), $urandom_range(0, 3),
                $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 99) < 80), 18'($urandom));
    end
    @(negedge clk);
    quiet();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
